// File: rtl/unidad_cortocircuito_pkg.sv
// Shared definitions for the forwarding / load-use hazard unit.
//   REG_W, FWD_W        : default register-address and forwarding-select widths
//   FWD_REG/EXMEM/MEMWB : operand-mux select codes
//   etapa_t             : ID/EX shadow record {rs, rt, rd, regwrite, memread}
//   etapa_wb_t          : EX/MEM and MEM/WB shadow record {rd, regwrite}
package unidad_cortocircuito_pkg;

  localparam int unsigned REG_W = 5;
  localparam int unsigned FWD_W = 3;

  localparam logic [FWD_W-1:0] FWD_REG   = 3'b000;
  localparam logic [FWD_W-1:0] FWD_EXMEM = 3'b001;
  localparam logic [FWD_W-1:0] FWD_MEMWB = 3'b010;

  typedef struct packed {
    logic [REG_W-1:0] rs;
    logic [REG_W-1:0] rt;
    logic [REG_W-1:0] rd;
    logic             regwrite;
    logic             memread;
  } etapa_t;

  typedef struct packed {
    logic [REG_W-1:0] rd;
    logic             regwrite;
  } etapa_wb_t;

endpackage

// File: rtl/unidad_cortocircuito_selector.sv
// cortocircuito_selector: forwarding select for one ALU source register.
//   i_fuente             : source register of the instruction in EX
//   i_exmem_rd/regwrite  : destination info of the instruction in MEM
//   i_memwb_rd/regwrite  : destination info of the instruction in WB
//   o_sel                : FWD_EXMEM, else FWD_MEMWB, else FWD_REG
// The younger producer (EX/MEM) wins; register 0 never forwards.
module cortocircuito_selector
  import unidad_cortocircuito_pkg::*;
#(
  parameter int unsigned REGBITS       = 5,
  parameter int unsigned CORTOCIRCUITO = 3
) (
  input  logic [REGBITS-1:0]       i_fuente,
  input  logic [REGBITS-1:0]       i_exmem_rd,
  input  logic                     i_exmem_regwrite,
  input  logic [REGBITS-1:0]       i_memwb_rd,
  input  logic                     i_memwb_regwrite,
  output logic [CORTOCIRCUITO-1:0] o_sel
);

  logic hit_exmem;
  logic hit_memwb;

  always_comb begin
    hit_exmem = i_exmem_regwrite && (i_exmem_rd != '0) && (i_exmem_rd == i_fuente);
    hit_memwb = i_memwb_regwrite && (i_memwb_rd != '0) && (i_memwb_rd == i_fuente);
  end

  always_comb begin
    o_sel = CORTOCIRCUITO'(FWD_REG);
    if (hit_exmem) begin
      o_sel = CORTOCIRCUITO'(FWD_EXMEM);
    end else if (hit_memwb) begin
      o_sel = CORTOCIRCUITO'(FWD_MEMWB);
    end
  end

endmodule

// File: rtl/unidad_cortocircuito.sv
// unidad_cortocircuito: forwarding and load-use hazard unit, 5-stage MIPS.
// Keeps shadow destination info for ID/EX, EX/MEM and MEM/WB.
//   i_clk, i_reset (async, active low), i_enable (advance), i_flush (bubble)
//   i_IF_ID_Rs/Rt/UsaRt : sources of the instruction in decode
//   i_ID_Rd/RegWrite/MemRead : destination info of the instruction in decode
//   o_EX_CortocircuitoA/B : operand mux selects for the instruction in EX
//   o_Stall : load-use stall (hold PC and IF/ID, bubble ID/EX)
module unidad_cortocircuito
  import unidad_cortocircuito_pkg::*;
#(
  parameter int unsigned REGBITS       = 5,
  parameter int unsigned CORTOCIRCUITO = 3
) (
  input  logic                     i_clk,
  input  logic                     i_reset,
  input  logic                     i_enable,
  input  logic                     i_flush,
  input  logic [REGBITS-1:0]       i_IF_ID_Rs,
  input  logic [REGBITS-1:0]       i_IF_ID_Rt,
  input  logic                     i_IF_ID_UsaRt,
  input  logic [REGBITS-1:0]       i_ID_Rd,
  input  logic                     i_ID_RegWrite,
  input  logic                     i_ID_MemRead,
  output logic [CORTOCIRCUITO-1:0] o_EX_CortocircuitoA,
  output logic [CORTOCIRCUITO-1:0] o_EX_CortocircuitoB,
  output logic                     o_Stall
);

  etapa_t    id_ex;
  etapa_wb_t ex_mem;
  etapa_wb_t mem_wb;
  logic      stall;

  // Load in EX whose destination is read by the instruction in decode.
  always_comb begin
    stall = id_ex.memread && (id_ex.rd != '0) &&
            ((id_ex.rd == i_IF_ID_Rs) || (i_IF_ID_UsaRt && (id_ex.rd == i_IF_ID_Rt)));
  end

  assign o_Stall = stall;

  always_ff @(posedge i_clk or negedge i_reset) begin
    if (!i_reset) begin
      id_ex  <= '0;
      ex_mem <= '0;
      mem_wb <= '0;
    end else if (i_enable) begin
      mem_wb <= ex_mem;
      ex_mem <= '{rd: id_ex.rd, regwrite: id_ex.regwrite};
      // A bubble clears memread, so a load-use stall lasts one cycle.
      if (stall || i_flush) begin
        id_ex <= '0;
      end else begin
        id_ex <= '{rs:       i_IF_ID_Rs,
                   rt:       i_IF_ID_Rt,
                   rd:       i_ID_Rd,
                   regwrite: i_ID_RegWrite,
                   memread:  i_ID_MemRead};
      end
    end
  end

  cortocircuito_selector #(
    .REGBITS      (REGBITS),
    .CORTOCIRCUITO(CORTOCIRCUITO)
  ) u_sel_a (
    .i_fuente        (id_ex.rs),
    .i_exmem_rd      (ex_mem.rd),
    .i_exmem_regwrite(ex_mem.regwrite),
    .i_memwb_rd      (mem_wb.rd),
    .i_memwb_regwrite(mem_wb.regwrite),
    .o_sel           (o_EX_CortocircuitoA)
  );

  cortocircuito_selector #(
    .REGBITS      (REGBITS),
    .CORTOCIRCUITO(CORTOCIRCUITO)
  ) u_sel_b (
    .i_fuente        (id_ex.rt),
    .i_exmem_rd      (ex_mem.rd),
    .i_exmem_regwrite(ex_mem.regwrite),
    .i_memwb_rd      (mem_wb.rd),
    .i_memwb_regwrite(mem_wb.regwrite),
    .o_sel           (o_EX_CortocircuitoB)
  );

endmodule

// File: tb/tb_unidad_cortocircuito.sv
// Self-checking bench for unidad_cortocircuito: a table of decode-stage
// instructions with hand-computed selects/stall, plus directed sequences
// for hold, flush and asynchronous reset mid-stall.
module tb_unidad_cortocircuito;

  logic       i_clk;
  logic       i_reset;
  logic       i_enable;
  logic       i_flush;
  logic [4:0] i_IF_ID_Rs;
  logic [4:0] i_IF_ID_Rt;
  logic       i_IF_ID_UsaRt;
  logic [4:0] i_ID_Rd;
  logic       i_ID_RegWrite;
  logic       i_ID_MemRead;
  logic [2:0] o_EX_CortocircuitoA;
  logic [2:0] o_EX_CortocircuitoB;
  logic       o_Stall;

  int n_checks = 0;
  int n_fail   = 0;

  unidad_cortocircuito #(
    .REGBITS      (5),
    .CORTOCIRCUITO(3)
  ) dut (
    .i_clk              (i_clk),
    .i_reset            (i_reset),
    .i_enable           (i_enable),
    .i_flush            (i_flush),
    .i_IF_ID_Rs         (i_IF_ID_Rs),
    .i_IF_ID_Rt         (i_IF_ID_Rt),
    .i_IF_ID_UsaRt      (i_IF_ID_UsaRt),
    .i_ID_Rd            (i_ID_Rd),
    .i_ID_RegWrite      (i_ID_RegWrite),
    .i_ID_MemRead       (i_ID_MemRead),
    .o_EX_CortocircuitoA(o_EX_CortocircuitoA),
    .o_EX_CortocircuitoB(o_EX_CortocircuitoB),
    .o_Stall            (o_Stall)
  );

  initial i_clk = 1'b0;
  always #5 i_clk = ~i_clk;

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish within time limit");
    $fatal(1, "watchdog");
  end

  // One decode-stage instruction and the outputs expected during that cycle
  // (selects describe the instruction already in EX).
  typedef struct {
    logic [4:0] rs;
    logic [4:0] rt;
    logic       usa_rt;
    logic [4:0] rd;
    logic       rw;
    logic       mr;
    logic       flush;
    logic [2:0] exp_a;
    logic [2:0] exp_b;
    logic       exp_stall;
  } vec_t;

  localparam int NV = 22;
  vec_t tbl [NV];

  function automatic vec_t mk(input logic [4:0] rs, input logic [4:0] rt,
                              input logic usa_rt, input logic [4:0] rd,
                              input logic rw, input logic mr, input logic flush,
                              input logic [2:0] ea, input logic [2:0] eb,
                              input logic es);
    vec_t v;
    v.rs = rs; v.rt = rt; v.usa_rt = usa_rt; v.rd = rd; v.rw = rw; v.mr = mr;
    v.flush = flush; v.exp_a = ea; v.exp_b = eb; v.exp_stall = es;
    return v;
  endfunction

  task automatic check(input string name, input logic [2:0] act, input logic [2:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %b expected %b (t=%0t)", name, act, exp, $time);
    end
  endtask

  task automatic drive(input vec_t v);
    i_IF_ID_Rs    = v.rs;
    i_IF_ID_Rt    = v.rt;
    i_IF_ID_UsaRt = v.usa_rt;
    i_ID_Rd       = v.rd;
    i_ID_RegWrite = v.rw;
    i_ID_MemRead  = v.mr;
    i_flush       = v.flush;
  endtask

  task automatic check_outs(input string tag, input vec_t v);
    check({tag, ".A"},     o_EX_CortocircuitoA, v.exp_a);
    check({tag, ".B"},     o_EX_CortocircuitoB, v.exp_b);
    check({tag, ".stall"}, {2'b00, o_Stall},    {2'b00, v.exp_stall});
  endtask

  // Drive, settle, check, then advance one clock (inputs change #1 after edge).
  task automatic step(input string tag, input vec_t v);
    drive(v);
    #1;
    check_outs(tag, v);
    @(posedge i_clk);
    #1;
  endtask

  vec_t nop;
  vec_t v;

  initial begin
    nop = mk(0, 0, 0, 0, 0, 0, 0, 3'b000, 3'b000, 1'b0);
    //              rs  rt ut rd rw mr fl   A       B      stall
    tbl[0]  = mk(1,  2, 1, 3, 1, 0, 0, 3'b000, 3'b000, 0); // add $3,$1,$2
    tbl[1]  = mk(3,  5, 1, 4, 1, 0, 0, 3'b000, 3'b000, 0); // sub $4,$3,$5
    tbl[2]  = mk(0,  0, 0, 0, 0, 0, 0, 3'b001, 3'b000, 0); // nop  (sub in EX)
    tbl[3]  = mk(1,  2, 1, 3, 1, 0, 0, 3'b000, 3'b000, 0); // add $3
    tbl[4]  = mk(0,  0, 0, 0, 0, 0, 0, 3'b000, 3'b000, 0); // nop
    tbl[5]  = mk(3,  3, 1, 6, 1, 0, 0, 3'b000, 3'b000, 0); // and $6,$3,$3
    tbl[6]  = mk(1,  2, 1, 3, 1, 0, 0, 3'b010, 3'b010, 0); // add $3 (and in EX)
    tbl[7]  = mk(1,  2, 1, 3, 1, 0, 0, 3'b000, 3'b000, 0); // or $3,$1,$2
    tbl[8]  = mk(3,  1, 1, 7, 1, 0, 0, 3'b000, 3'b000, 0); // xor $7,$3,$1
    tbl[9]  = mk(1,  2, 1, 0, 1, 0, 0, 3'b001, 3'b000, 0); // add $0 (xor in EX)
    tbl[10] = mk(0,  0, 1, 4, 1, 0, 0, 3'b000, 3'b000, 0); // sub $4,$0,$0
    tbl[11] = mk(0,  0, 0, 0, 0, 0, 0, 3'b000, 3'b000, 0); // nop (sub $0 in EX)
    tbl[12] = mk(1,  8, 0, 8, 1, 1, 0, 3'b000, 3'b000, 0); // lw $8,0($1)
    tbl[13] = mk(8,  2, 1, 9, 1, 0, 0, 3'b000, 3'b000, 1); // add $9,$8,$2 stalls
    tbl[14] = mk(8,  2, 1, 9, 1, 0, 0, 3'b000, 3'b000, 0); // add held, bubble in EX
    tbl[15] = mk(0,  0, 0, 0, 0, 0, 0, 3'b010, 3'b000, 0); // nop (add in EX)
    tbl[16] = mk(1,  8, 0, 8, 1, 1, 0, 3'b000, 3'b000, 0); // lw $8,0($1)
    tbl[17] = mk(1,  8, 1, 0, 0, 0, 0, 3'b000, 3'b000, 1); // sw $8 stalls via rt
    tbl[18] = mk(1,  8, 1, 0, 0, 0, 0, 3'b000, 3'b000, 0); // sw held, bubble in EX
    tbl[19] = mk(1,  8, 0, 8, 1, 1, 0, 3'b000, 3'b010, 0); // lw $8 (sw in EX)
    tbl[20] = mk(1,  8, 0, 0, 0, 0, 0, 3'b000, 3'b000, 0); // rt=8 unused: no stall
    tbl[21] = mk(0,  0, 0, 0, 0, 0, 0, 3'b000, 3'b001, 0); // nop (rt=8 from EX/MEM)

    // Reset held: everything zero.
    i_reset  = 1'b0;
    i_enable = 1'b1;
    drive(mk(8, 8, 1, 8, 1, 1, 0, 0, 0, 0));
    @(posedge i_clk);
    #2;
    check_outs("reset_held", nop);
    #3;
    i_reset = 1'b1;
    drive(nop);
    @(posedge i_clk);
    #1;

    // Main table.
    for (int i = 0; i < NV; i++) begin
      step($sformatf("vec%0d", i), tbl[i]);
    end

    // Drain pipeline.
    for (int i = 0; i < 3; i++) step("drain0", nop);

    // Hold: sub depends on add; freeze for 3 cycles with noisy decode inputs.
    step("hold_add", nop);
    drive(mk(1, 2, 1, 3, 1, 0, 0, 0, 0, 0)); @(posedge i_clk); #1;
    drive(mk(3, 5, 1, 4, 1, 0, 0, 0, 0, 0)); @(posedge i_clk); #1;
    v = mk(3, 5, 1, 4, 1, 0, 0, 3'b001, 3'b000, 0);
    #1; check_outs("dep_before_hold", v);
    i_enable = 1'b0;
    for (int i = 0; i < 3; i++) begin
      drive(mk(9, 9, 1, 9, 1, 1, 1, 3'b001, 3'b000, 0));
      @(posedge i_clk);
      #1;
      check_outs($sformatf("hold%0d", i), mk(0, 0, 0, 0, 0, 0, 0, 3'b001, 3'b000, 0));
    end
    i_enable = 1'b1;
    step("hold_release", mk(0, 0, 0, 0, 0, 0, 0, 3'b001, 3'b000, 0));
    step("after_hold", nop);
    for (int i = 0; i < 3; i++) step("drain1", nop);

    // Flush together with a stalling pair.
    step("fl_lw", mk(1, 8, 0, 8, 1, 1, 0, 3'b000, 3'b000, 0));
    step("fl_pair", mk(8, 2, 1, 9, 1, 0, 1, 3'b000, 3'b000, 1));
    step("fl_after", mk(0, 0, 0, 0, 0, 0, 0, 3'b000, 3'b000, 0));
    // Flush alone: add $3 becomes a bubble, so a later reader of $3 gets nothing.
    step("fl_add", mk(1, 2, 1, 3, 1, 0, 1, 3'b000, 3'b000, 0));
    step("fl_sub", mk(3, 3, 1, 4, 1, 0, 0, 3'b000, 3'b000, 0));
    step("fl_chk", mk(0, 0, 0, 0, 0, 0, 0, 3'b000, 3'b000, 0));
    for (int i = 0; i < 3; i++) step("drain2", nop);

    // Asynchronous reset mid-stall: add $1 ; lw $8,0($1) ; add $9,$8,$2.
    step("rs_add", mk(2, 3, 1, 1, 1, 0, 0, 3'b000, 3'b000, 0));
    step("rs_lw",  mk(1, 8, 0, 8, 1, 1, 0, 3'b000, 3'b000, 0));
    drive(mk(8, 2, 1, 9, 1, 0, 0, 0, 0, 0));
    #1;
    check_outs("rs_stall", mk(0, 0, 0, 0, 0, 0, 0, 3'b001, 3'b000, 1));
    #1;
    i_reset = 1'b0;
    #1;
    check_outs("rs_async", nop);
    @(posedge i_clk);
    #3;
    i_reset = 1'b1;
    #1;
    check_outs("rs_released", nop);
    @(posedge i_clk);
    #1;
    check_outs("rs_first_cycle", nop);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
